// File: rtl/ka283_pkg.sv
// Shared widths and FSM encoding for the 283-bit carry-less multiply scheduler.
package ka283_pkg;

  localparam int unsigned OP_W   = 283;
  localparam int unsigned PROD_W = 565;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

// File: rtl/KA_283bit.sv
// Combinational 283x283 GF(2) polynomial multiplier, unreduced 565-bit product.
module KA_283bit (
  input  logic [282:0] a,
  input  logic [282:0] b,
  output logic [564:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < 283; i++) begin
      if (b[i]) y = y ^ (565'(a) << i);
    end
  end

endmodule

// File: rtl/ka283_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester that wins a tie.
module ka283_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic ptr;

  assign grant0 = en && valid0 && (!valid1 || !ptr);
  assign grant1 = en && valid1 && (!valid0 || ptr);

  // Pointer moves only on an actual grant, so a withdrawn request leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/ka283_mul_sched.sv
// Schedules two requesters onto one multicycle KA_283bit multiplier with a
// valid/ready response port.
module ka283_mul_sched
  import ka283_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [282:0] req0_a,
  input  logic [282:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [282:0] req1_a,
  input  logic [282:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [564:0] rsp_y,
  output logic         busy
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic               op_id;
  logic [PROD_W-1:0]  mul_y;
  logic               arb_en;
  logic               gnt0;
  logic               gnt1;

  // Grants are only offered from IDLE and never while reset is asserted.
  assign arb_en     = rst_n && (state == IDLE);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  ka283_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (gnt0),
    .grant1 (gnt1)
  );

  // Timing: set_multicycle_path -setup MUL_LAT (hold MUL_LAT-1) from op_a/op_b to rsp_y.
  KA_283bit u_mul (op_a, op_b, mul_y);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_a  <= gnt1 ? req1_a : req0_a;
            op_b  <= gnt1 ? req1_b : req0_b;
            op_id <= gnt1;
            cnt   <= CNT_W'(MUL_LAT - 1);
            state <= COMPUTE;
            busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          // Operands stay frozen here; the product is sampled after MUL_LAT cycles.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_y     <= mul_y;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ka283_mul_sched.sv
// Directed bench for ka283_mul_sched: main instance at MUL_LAT=2, plus
// MUL_LAT=1 and MUL_LAT=15 instances for the latency bounds.
module tb_ka283_mul_sched;

  logic         clk;
  logic         rst_n;
  logic         r0v, r1v, rspr;
  logic [282:0] r0a, r0b, r1a, r1b;
  logic         r0r, r1r, rsp_valid, rsp_id, busy;
  logic [564:0] rsp_y;

  logic         xv;
  logic [282:0] xa, xb;
  logic         l1_r0r, l1_r1r, l1_rv, l1_id, l1_busy;
  logic [564:0] l1_y;
  logic         l15_r0r, l15_r1r, l15_rv, l15_id, l15_busy;
  logic [564:0] l15_y;

  int n_cmp = 0;
  int n_err = 0;

  ka283_mul_sched #(.MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
    .rsp_valid(rsp_valid), .rsp_ready(rspr), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .busy(busy)
  );

  ka283_mul_sched #(.MUL_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(xv), .req0_ready(l1_r0r), .req0_a(xa), .req0_b(xb),
    .req1_valid(1'b0), .req1_ready(l1_r1r), .req1_a('0), .req1_b('0),
    .rsp_valid(l1_rv), .rsp_ready(1'b1), .rsp_id(l1_id), .rsp_y(l1_y),
    .busy(l1_busy)
  );

  ka283_mul_sched #(.MUL_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(xv), .req0_ready(l15_r0r), .req0_a(xa), .req0_b(xb),
    .req1_valid(1'b0), .req1_ready(l15_r1r), .req1_a('0), .req1_b('0),
    .rsp_valid(l15_rv), .rsp_ready(1'b1), .rsp_id(l15_id), .rsp_y(l15_y),
    .busy(l15_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [564:0] got, input logic [564:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, check the grant, and complete the handshake.
  task automatic issue(input string tag, input logic id, input logic [282:0] a, input logic [282:0] b);
    if (id) begin r1v = 1'b1; r1a = a; r1b = b; end
    else    begin r0v = 1'b1; r0a = a; r0b = b; end
    #1;
    chk({tag, "_r0rdy"}, 565'(r0r), 565'(!id));
    chk({tag, "_r1rdy"}, 565'(r1r), 565'(id));
    tick();
    r0v = 1'b0;
    r1v = 1'b0;
  endtask

  // Called one step after the handshake edge; counts cycles to rsp_valid.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_id, input logic [564:0] exp_y);
    int n;
    n = 1;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 565'(n), 565'(exp_lat));
    chk({tag, "_id"}, 565'(rsp_id), 565'(exp_id));
    chk({tag, "_y"}, rsp_y, exp_y);
  endtask

  task automatic consume(input string tag);
    rspr = 1'b1;
    tick();
    chk({tag, "_vld_off"}, 565'(rsp_valid), 565'(0));
    chk({tag, "_busy_off"}, 565'(busy), 565'(0));
  endtask

  initial begin
    logic [282:0] hb;
    logic [564:0] hp;
    int           n1, n15;
    hb = 283'(1) << 282;
    hp = 565'(1) << 564;

    rst_n = 1'b0; rspr = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    r0a = '0; r0b = '0; r1a = '0; r1b = '0;
    xv = 1'b0; xa = 283'd3; xb = 283'd3;

    // Reset: requests present but nothing granted, outputs quiet.
    tick(); tick();
    chk("rst_vld", 565'(rsp_valid), 565'(0));
    chk("rst_busy", 565'(busy), 565'(0));
    chk("rst_r0rdy", 565'(r0r), 565'(0));
    chk("rst_r1rdy", 565'(r1r), 565'(0));
    chk("rst_y", rsp_y, 565'(0));

    // Simultaneous requests right after reset: req0 first, then req1.
    r0v = 1'b0; r1v = 1'b0;
    rst_n = 1'b1;
    tick();
    r0v = 1'b1; r0a = 283'd2; r0b = 283'd3;
    r1v = 1'b1; r1a = 283'd5; r1b = 283'd5;
    #1;
    chk("sim_r0rdy", 565'(r0r), 565'(1));
    chk("sim_r1rdy", 565'(r1r), 565'(0));
    tick();
    r0v = 1'b0;
    chk("sim_cmp_r1rdy", 565'(r1r), 565'(0));
    chk("sim_cmp_busy", 565'(busy), 565'(1));
    wait_rsp("sim0", 3, 1'b0, 565'h6);
    tick();
    chk("sim_gap_vld", 565'(rsp_valid), 565'(0));
    chk("sim_r1rdy2", 565'(r1r), 565'(1));
    tick();
    r1v = 1'b0;
    wait_rsp("sim1", 3, 1'b1, 565'h11);
    consume("sim1");

    // Basic latency and carry-less arithmetic.
    issue("basic", 1'b0, 283'd1, 283'd1);
    wait_rsp("basic", 3, 1'b0, 565'h1);
    consume("basic");
    issue("clm33", 1'b1, 283'd3, 283'd3);
    wait_rsp("clm33", 3, 1'b1, 565'h5);
    consume("clm33");
    issue("top", 1'b1, hb, hb);
    wait_rsp("top", 3, 1'b1, hp);
    consume("top");

    // Backpressure: response held, new requests refused.
    rspr = 1'b0;
    issue("bp", 1'b0, 283'd7, 283'd5);
    wait_rsp("bp", 3, 1'b0, 565'h1B);
    r0v = 1'b1; r1v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vld", 565'(rsp_valid), 565'(1));
      chk("bp_y", rsp_y, 565'h1B);
      chk("bp_id", 565'(rsp_id), 565'(0));
      chk("bp_r0rdy", 565'(r0r), 565'(0));
      chk("bp_r1rdy", 565'(r1r), 565'(0));
      chk("bp_busy", 565'(busy), 565'(1));
    end
    r0v = 1'b0; r1v = 1'b0;
    consume("bp");

    // Withdrawn requests left the pointer at req1 after the req0 grant.
    r0v = 1'b1; r0a = 283'd1; r0b = 283'd1;
    r1v = 1'b1; r1a = 283'd6; r1b = 283'd3;
    #1;
    chk("ptr_r0rdy", 565'(r0r), 565'(0));
    chk("ptr_r1rdy", 565'(r1r), 565'(1));
    tick();
    r0v = 1'b0; r1v = 1'b0;
    wait_rsp("ptr", 3, 1'b1, 565'hA);
    consume("ptr");

    // Reset during COMPUTE, with pointer left at req1 beforehand.
    issue("mid", 1'b0, 283'd3, 283'd3);
    rst_n = 1'b0;
    tick();
    chk("mid_vld", 565'(rsp_valid), 565'(0));
    chk("mid_busy", 565'(busy), 565'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_norsp", 565'(rsp_valid), 565'(0));
    end
    r0v = 1'b1; r0a = 283'd3; r0b = 283'd1;
    r1v = 1'b1; r1a = 283'd1; r1b = 283'd1;
    #1;
    chk("mid_r0rdy", 565'(r0r), 565'(1));
    chk("mid_r1rdy", 565'(r1r), 565'(0));
    tick();
    r0v = 1'b0; r1v = 1'b0;
    wait_rsp("mid", 3, 1'b0, 565'h3);
    consume("mid");

    // Latency bounds on the MUL_LAT=1 and MUL_LAT=15 instances.
    xv = 1'b1;
    #1;
    chk("lb1_rdy", 565'(l1_r0r), 565'(1));
    chk("lb15_rdy", 565'(l15_r0r), 565'(1));
    tick();
    xv = 1'b0;
    n1 = 0; n15 = 0;
    for (int n = 1; n < 40; n++) begin
      if (l1_rv && n1 == 0) begin
        n1 = n;
        chk("lb1_y", l1_y, 565'h5);
      end
      if (l15_rv && n15 == 0) begin
        n15 = n;
        chk("lb15_y", l15_y, 565'h5);
      end
      if (n1 != 0 && n15 != 0) break;
      tick();
    end
    chk("lb1_lat", 565'(n1), 565'(2));
    chk("lb15_lat", 565'(n15), 565'(16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
